wfg_drive_uart: RTL

Downstream consumer of the 32-bit waveform AXI-Stream produced by the stimulus sources (e.g. the stimulus memory). Accepts one 32-bit word per handshake and serialises 1–4 of its bytes, least significant byte first, as standard asynchronous UART frames on a single output pin. Bit period, byte count, parity and stop-bit count come from register-file outputs.

---
 rtl/wfg_drive_uart.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wfg_drive_uart.sv
// wfg_drive_uart
// Serialises 1-4 bytes of each 32-bit AXI-Stream word as asynchronous UART
// frames (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
//
// Handshake: a word transfers on a rising edge where tvalid and tready are
// both high. tready is high only while idle and enabled, never depends on
// tvalid, and the source must hold tdata stable while tvalid is high.
module wfg_drive_uart (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wfg_axis_tready_o,
    input  logic        wfg_axis_tvalid_i,
    input  logic [31:0] wfg_axis_tdata_i,
    input  logic        ctrl_en_q_i,
    input  logic [15:0] clkdiv_q_i,
    input  logic [1:0]  cfg_nbytes_q_i,
    input  logic [1:0]  cfg_parity_q_i,
    input  logic        cfg_stop2_q_i,
    output logic        uart_tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      state;
    logic        armed;      // low only during and right after reset so tready stays 0 in reset
    logic        tx;
    logic [31:0] data_q;
    logic [15:0] clkdiv_q;
    logic [1:0]  nbytes_q;
    logic [1:0]  parity_q;
    logic        stop2_q;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] bit_cnt;
    logic        stop_cnt;   // 0 = first stop bit, 1 = second stop bit

    logic [7:0]  cur_byte;
    logic        parity_en;
    logic        parity_bit;
    logic        hs;

    assign wfg_axis_tready_o = armed && (state == ST_IDLE) && ctrl_en_q_i;
    assign hs                = wfg_axis_tready_o && wfg_axis_tvalid_i;
    assign busy_o            = (state != ST_IDLE);
    assign uart_tx_o         = tx;

    // Select the byte currently being framed and derive its parity bit
    always_comb begin
        cur_byte = data_q[7:0];
        case (byte_idx)
            2'd0:    cur_byte = data_q[7:0];
            2'd1:    cur_byte = data_q[15:8];
            2'd2:    cur_byte = data_q[23:16];
            default: cur_byte = data_q[31:24];
        endcase
        parity_en  = (parity_q == 2'b01) || (parity_q == 2'b10);
        // Odd parity (10) is the inverse of even parity (01)
        parity_bit = (^cur_byte) ^ parity_q[1];
    end

    // Frame sequencer: every state change also sets the line level of the next bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            tx       <= 1'b1;
            data_q   <= '0;
            clkdiv_q <= '0;
            nbytes_q <= '0;
            parity_q <= '0;
            stop2_q  <= 1'b0;
            byte_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            armed <= 1'b1;
            if ((state != ST_IDLE) && !ctrl_en_q_i) begin
                // Abort: drop the word and return the line to idle
                state    <= ST_IDLE;
                tx       <= 1'b1;
                byte_idx <= '0;
                bit_idx  <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (hs) begin
                            data_q   <= wfg_axis_tdata_i;
                            clkdiv_q <= clkdiv_q_i;
                            nbytes_q <= cfg_nbytes_q_i;
                            parity_q <= cfg_parity_q_i;
                            stop2_q  <= cfg_stop2_q_i;
                            byte_idx <= '0;
                            bit_cnt  <= clkdiv_q_i;
                            state    <= ST_START;
                            tx       <= 1'b0;
                        end
                    end
                    ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                        if (bit_cnt != 16'd0) begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end else begin
                            bit_cnt <= clkdiv_q;
                            case (state)
                                ST_START: begin
                                    state   <= ST_DATA;
                                    bit_idx <= 3'd0;
                                    tx      <= cur_byte[0];
                                end
                                ST_DATA: begin
                                    if (bit_idx == 3'd7) begin
                                        if (parity_en) begin
                                            state <= ST_PARITY;
                                            tx    <= parity_bit;
                                        end else begin
                                            state    <= ST_STOP;
                                            tx       <= 1'b1;
                                            stop_cnt <= 1'b0;
                                        end
                                    end else begin
                                        bit_idx <= bit_idx + 3'd1;
                                        tx      <= cur_byte[bit_idx + 3'd1];
                                    end
                                end
                                ST_PARITY: begin
                                    state    <= ST_STOP;
                                    tx       <= 1'b1;
                                    stop_cnt <= 1'b0;
                                end
                                ST_STOP: begin
                                    if (stop2_q && !stop_cnt) begin
                                        stop_cnt <= 1'b1;
                                    end else if (byte_idx != nbytes_q) begin
                                        // Next byte starts right after the stop bit, no gap
                                        byte_idx <= byte_idx + 2'd1;
                                        state    <= ST_START;
                                        tx       <= 1'b0;
                                    end else begin
                                        state <= ST_IDLE;
                                        tx    <= 1'b1;
                                    end
                                end
                                default: begin
                                    state <= ST_IDLE;
                                    tx    <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
